// File: rtl/cache_pkg.sv
// Shared encodings and byte-lane helpers for the N-way data cache.
// Access modes follow the load/store funct3 layout.
package cache_pkg;

  localparam logic [2:0] DATA_ADDR_MODE_B  = 3'b000;
  localparam logic [2:0] DATA_ADDR_MODE_H  = 3'b001;
  localparam logic [2:0] DATA_ADDR_MODE_W  = 3'b010;
  localparam logic [2:0] DATA_ADDR_MODE_BU = 3'b100;
  localparam logic [2:0] DATA_ADDR_MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STORE,
    ST_RESP
  } cache_state_e;

  function automatic logic [3:0] byte_enable(input logic [2:0] mode, input logic [1:0] off);
    logic [3:0] be;
    case (mode)
      DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: be = 4'b0001 << off;
      DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: be = 4'b0011 << {off[1], 1'b0};
      default:                             be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_shift(input logic [2:0] mode, input logic [1:0] off,
                                             input logic [31:0] wd);
    logic [31:0] r;
    case (mode)
      DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: r = {24'd0, wd[7:0]} << {off, 3'b000};
      DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: r = {16'd0, wd[15:0]} << {off[1], 4'b0000};
      default:                             r = wd;
    endcase
    return r;
  endfunction

  // Right-aligns the addressed lane and sign- or zero-extends it.
  function automatic logic [31:0] extract(input logic [2:0] mode, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [31:0] sb;
    logic [31:0] sh;
    logic [31:0] r;
    sb = word >> {off, 3'b000};
    sh = word >> {off[1], 4'b0000};
    case (mode)
      DATA_ADDR_MODE_B:  r = {{24{sb[7]}}, sb[7:0]};
      DATA_ADDR_MODE_BU: r = {24'd0, sb[7:0]};
      DATA_ADDR_MODE_H:  r = {{16{sh[15]}}, sh[15:0]};
      DATA_ADDR_MODE_HU: r = {16'd0, sh[15:0]};
      default:           r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// True-LRU age tracker: per-set age per way, 0 = most recent, NUM_WAYS-1 = oldest.
module lru_tracker #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_SETS)-1:0] lookup_set,
  output logic [$clog2(NUM_WAYS)-1:0] oldest_way,
  input  logic                        touch_en,
  input  logic [$clog2(NUM_SETS)-1:0] touch_set,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way
);

  localparam int WW = $clog2(NUM_WAYS);

  logic [WW-1:0] ages_q [NUM_SETS][NUM_WAYS];
  logic [WW-1:0] ages_d [NUM_SETS][NUM_WAYS];
  logic [WW-1:0] touched_age;

  // Touched way becomes youngest; only ways younger than it age by one.
  always_comb begin
    ages_d      = ages_q;
    touched_age = ages_q[touch_set][touch_way];
    if (touch_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WW'(w) == touch_way)
          ages_d[touch_set][w] = '0;
        else if (ages_q[touch_set][w] < touched_age)
          ages_d[touch_set][w] = ages_q[touch_set][w] + WW'(1);
      end
    end
  end

  always_comb begin
    oldest_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages_q[lookup_set][w] == WW'(NUM_WAYS - 1))
        oldest_way = WW'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          ages_q[s][w] <= WW'(w);
    end else begin
      ages_q <= ages_d;
    end
  end

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-through, no-write-allocate data cache with
// true-LRU replacement, req/ack memory handshake and a flush port.
module nway_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_mode,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  output logic [DATA_WIDTH-1:0] cpu_rd,
  output logic                  cpu_ready,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  input  logic                  mem_ack,
  output logic [31:0]           total_accesses,
  output logic [31:0]           total_hits,
  output logic [31:0]           total_misses
);

  localparam int SW = $clog2(NUM_SETS);
  localparam int WW = $clog2(NUM_WAYS);
  localparam int TW = ADDR_WIDTH - 2 - SW;

  logic [SW-1:0] set_idx;
  logic [TW-1:0] tag;
  logic [1:0]    off;

  assign set_idx  = cpu_addr[2+SW-1:2];
  assign tag      = cpu_addr[ADDR_WIDTH-1:2+SW];
  assign off      = cpu_addr[1:0];
  assign mem_addr = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wd   = lane_shift(cpu_mode, off, cpu_wd);

  cache_state_e state_q, state_d;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
  logic [TW-1:0]         tag_q   [NUM_SETS][NUM_WAYS];
  logic [TW-1:0]         tag_d   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_d  [NUM_SETS][NUM_WAYS];
  logic                  hit_q, hit_d;
  logic [WW-1:0]         way_q, way_d;
  logic [DATA_WIDTH-1:0] fill_word_q, fill_word_d;
  logic [31:0]           acc_q, acc_d, hits_q, hits_d, misses_q, misses_d;

  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim_way;
  logic [WW-1:0] oldest_way;
  logic          found_invalid;
  logic          touch_en;
  logic [WW-1:0] touch_way;
  logic          count_hit;

  assign total_accesses = acc_q;
  assign total_hits     = hits_q;
  assign total_misses   = misses_q;

  lru_tracker #(
    .NUM_SETS(NUM_SETS),
    .NUM_WAYS(NUM_WAYS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .lookup_set(set_idx),
    .oldest_way(oldest_way),
    .touch_en  (touch_en),
    .touch_set (set_idx),
    .touch_way (touch_way)
  );

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Prefer the lowest free way; only fall back to LRU when the set is full.
  always_comb begin
    victim_way    = oldest_way;
    found_invalid = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_invalid && !valid_q[set_idx][w]) begin
        victim_way    = WW'(w);
        found_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    hit_d       = hit_q;
    way_d       = way_q;
    fill_word_d = fill_word_q;
    cpu_ready   = 1'b0;
    cpu_rd      = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'b0000;
    touch_en    = 1'b0;
    touch_way   = way_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          for (int s = 0; s < NUM_SETS; s++)
            valid_d[s] = '0;
        end else if (cpu_req) begin
          hit_d = hit;
          way_d = hit ? hit_way : victim_way;
          if (cpu_we) begin
            state_d = ST_STORE;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rd    = extract(cpu_mode, off, data_q[set_idx][hit_way]);
            touch_en  = 1'b1;
            touch_way = hit_way;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          tag_d[set_idx][way_q]   = tag;
          data_d[set_idx][way_q]  = mem_rd;
          valid_d[set_idx][way_q] = 1'b1;
          fill_word_d             = mem_rd;
          touch_en                = 1'b1;
          state_d                 = ST_RESP;
        end
      end
      ST_RESP: begin
        cpu_ready = 1'b1;
        cpu_rd    = extract(cpu_mode, off, fill_word_q);
        state_d   = ST_IDLE;
      end
      ST_STORE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mem_be  = byte_enable(cpu_mode, off);
        if (mem_ack) begin
          cpu_ready = 1'b1;
          if (hit_q) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b])
                data_d[set_idx][way_q][8*b +: 8] = mem_wd[8*b +: 8];
            touch_en = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A same-cycle completion in IDLE is always a load hit.
  always_comb begin
    acc_d     = acc_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    count_hit = (state_q == ST_IDLE) || (state_q == ST_STORE && hit_q);
    if (cpu_ready) begin
      acc_d = acc_q + 32'd1;
      if (count_hit)
        hits_d = hits_q + 32'd1;
      else
        misses_d = misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hit_q       <= 1'b0;
      way_q       <= '0;
      fill_word_q <= '0;
      acc_q       <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        valid_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      way_q       <= way_d;
      fill_word_q <= fill_word_d;
      acc_q       <= acc_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_nway_cache.sv
// Self-checking bench for nway_cache: table of accesses driven through a
// scoreboard, plus hand-written reset and flush corner cases.
module tb_nway_cache;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, flush, mem_ack;
   logic [2:0]  cpu_mode;
   logic [31:0] cpu_addr, cpu_wd, cpu_rd, mem_addr, mem_wd, mem_rd;
   logic        cpu_ready, mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] total_accesses, total_hits, total_misses;

   always #5 clk = ~clk;

   nway_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(4), .NUM_WAYS(4)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
      .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_ready(cpu_ready),
      .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_be(mem_be), .mem_rd(mem_rd), .mem_ack(mem_ack),
      .total_accesses(total_accesses), .total_hits(total_hits), .total_misses(total_misses)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  mode;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] mem_word;
      int          ack_delay;
      logic        exp_hit;
      logic [31:0] exp_rd;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic        flush_before;
      logic        flush_mid;
   } vec_t;

   typedef struct {
      string       name;
      logic        is_load;
      logic [31:0] rd;
      int          lat;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] addr;
   } sb_t;

   vec_t vecs[$];
   vec_t post_vecs[$];
   sb_t  sb_q[$];

   int tests_run = 0;
   int tests_failed = 0;
   int exp_acc = 0, exp_hits = 0, exp_misses = 0;

   function automatic vec_t ld(string name, logic [2:0] mode, logic [31:0] addr,
                               logic [31:0] mem_word, int ack, logic hit, logic [31:0] rd,
                               logic fb = 1'b0, logic fm = 1'b0);
      vec_t v;
      v.name = name; v.we = 1'b0; v.mode = mode; v.addr = addr; v.wd = 32'h0;
      v.mem_word = mem_word; v.ack_delay = ack; v.exp_hit = hit; v.exp_rd = rd;
      v.exp_be = 4'h0; v.exp_wd = 32'h0; v.flush_before = fb; v.flush_mid = fm;
      return v;
   endfunction

   function automatic vec_t st(string name, logic [2:0] mode, logic [31:0] addr,
                               logic [31:0] wd, int ack, logic hit, logic [3:0] be,
                               logic [31:0] exp_wd);
      vec_t v;
      v.name = name; v.we = 1'b1; v.mode = mode; v.addr = addr; v.wd = wd;
      v.mem_word = 32'h0; v.ack_delay = ack; v.exp_hit = hit; v.exp_rd = 32'h0;
      v.exp_be = be; v.exp_wd = exp_wd; v.flush_before = 1'b0; v.flush_mid = 1'b0;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkCounters(input string name);
      checkOutput({name, " accesses"}, total_accesses, exp_acc);
      checkOutput({name, " hits"}, total_hits, exp_hits);
      checkOutput({name, " misses"}, total_misses, exp_misses);
   endtask

   // Drives one request, answers the memory side, scores the completion.
   task automatic applyStimulus(input vec_t v);
      sb_t         e;
      sb_t         got;
      int          req_cycles;
      bit          done;
      logic [3:0]  seen_be;
      logic [31:0] seen_wd, seen_addr;
      logic        seen_we;
      req_cycles = 0; done = 0; seen_be = 4'h0; seen_wd = 32'h0; seen_addr = 32'h0;
      seen_we = 1'b0;
      cpu_we = v.we; cpu_mode = v.mode; cpu_addr = v.addr; cpu_wd = v.wd; cpu_req = 1'b1;
      if (v.flush_before) begin
         flush = 1'b1;
         mem_ack = 1'b1;
         @(negedge clk);
         checkOutput({v.name, " ready during flush"}, {31'd0, cpu_ready}, 32'd0);
         checkOutput({v.name, " mem_req during flush"}, {31'd0, mem_req}, 32'd0);
         @(posedge clk); #1;
         flush = 1'b0;
         mem_ack = 1'b0;
      end
      e.name = v.name; e.is_load = !v.we; e.rd = v.exp_rd;
      e.lat = v.we ? v.ack_delay + 1 : (v.exp_hit ? 1 : v.ack_delay + 2);
      e.be = v.exp_be; e.wd = v.exp_wd; e.addr = {v.addr[31:2], 2'b00};
      sb_q.push_back(e);
      for (int c = 1; c <= 40 && !done; c++) begin
         if (mem_req) begin
            req_cycles++;
            seen_be = mem_be; seen_wd = mem_wd; seen_addr = mem_addr; seen_we = mem_we;
            if (v.flush_mid && req_cycles == 1 && v.ack_delay > 1) flush = 1'b1;
            if (req_cycles == v.ack_delay) begin
               mem_ack = 1'b1;
               mem_rd  = v.mem_word;
            end
         end
         @(negedge clk);
         if (cpu_ready) begin
            done = 1;
            if (sb_q.size() == 0) begin
               checkOutput({v.name, " scoreboard empty"}, 32'd0, 32'd1);
            end else begin
               got = sb_q.pop_front();
               checkOutput({got.name, " latency"}, c, got.lat);
               if (got.is_load) checkOutput({got.name, " cpu_rd"}, cpu_rd, got.rd);
               if (req_cycles > 0) begin
                  checkOutput({got.name, " mem_addr"}, seen_addr, got.addr);
                  checkOutput({got.name, " mem_we"}, {31'd0, seen_we}, {31'd0, !got.is_load});
               end
               if (!got.is_load) begin
                  checkOutput({got.name, " mem_be"}, {28'd0, seen_be}, {28'd0, got.be});
                  checkOutput({got.name, " mem_wd"}, seen_wd, got.wd);
               end
            end
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
         flush = 1'b0;
      end
      cpu_req = 1'b0;
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s timeout: got no cpu_ready, expected one within 40 cycles", v.name);
         void'(sb_q.pop_front());
      end else begin
         exp_acc++;
         if (v.exp_hit) exp_hits++; else exp_misses++;
         checkCounters(v.name);
      end
   endtask

   initial begin
      bit seen;
      vecs.push_back(ld("ld W 100 miss", DATA_ADDR_MODE_W, 32'h100, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF));
      vecs.push_back(ld("ld W 100 hit", DATA_ADDR_MODE_W, 32'h100, 32'h0, 1, 1, 32'hDEADBEEF));
      vecs.push_back(ld("ld B 113 miss", DATA_ADDR_MODE_B, 32'h113, 32'h80FF0000, 1, 0, 32'hFFFFFF80));
      vecs.push_back(ld("ld BU 113", DATA_ADDR_MODE_BU, 32'h113, 32'h0, 1, 1, 32'h00000080));
      vecs.push_back(ld("ld HU 112", DATA_ADDR_MODE_HU, 32'h112, 32'h0, 1, 1, 32'h000080FF));
      vecs.push_back(ld("ld B 112", DATA_ADDR_MODE_B, 32'h112, 32'h0, 1, 1, 32'hFFFFFFFF));
      vecs.push_back(ld("ld W 110", DATA_ADDR_MODE_W, 32'h110, 32'h0, 1, 1, 32'h80FF0000));
      vecs.push_back(ld("ld W 124 miss", DATA_ADDR_MODE_W, 32'h124, 32'h11223344, 2, 0, 32'h11223344));
      vecs.push_back(st("st B 125 hit", DATA_ADDR_MODE_B, 32'h125, 32'h000000AB, 2, 1, 4'b0010, 32'h0000AB00));
      vecs.push_back(ld("ld W 124 merged B", DATA_ADDR_MODE_W, 32'h124, 32'h0, 1, 1, 32'h1122AB44));
      vecs.push_back(st("st H 126 hit", DATA_ADDR_MODE_H, 32'h126, 32'h1234BEEF, 1, 1, 4'b1100, 32'hBEEF0000));
      vecs.push_back(ld("ld W 124 merged H", DATA_ADDR_MODE_W, 32'h124, 32'h0, 1, 1, 32'hBEEFAB44));
      vecs.push_back(st("st W 134 miss", DATA_ADDR_MODE_W, 32'h134, 32'hCAFEF00D, 1, 0, 4'b1111, 32'hCAFEF00D));
      vecs.push_back(ld("ld W 134 no alloc", DATA_ADDR_MODE_W, 32'h134, 32'h55555555, 1, 0, 32'h55555555));
      vecs.push_back(ld("fill t1", DATA_ADDR_MODE_W, 32'h1008, 32'hA1000001, 1, 0, 32'hA1000001));
      vecs.push_back(ld("fill t2", DATA_ADDR_MODE_W, 32'h2008, 32'hA2000002, 1, 0, 32'hA2000002));
      vecs.push_back(ld("fill t3", DATA_ADDR_MODE_W, 32'h3008, 32'hA3000003, 1, 0, 32'hA3000003));
      vecs.push_back(ld("fill t4", DATA_ADDR_MODE_W, 32'h4008, 32'hA4000004, 1, 0, 32'hA4000004));
      vecs.push_back(ld("fill t5 evicts t1", DATA_ADDR_MODE_W, 32'h5008, 32'hA5000005, 1, 0, 32'hA5000005));
      vecs.push_back(ld("touch t2", DATA_ADDR_MODE_W, 32'h2008, 32'h0, 1, 1, 32'hA2000002));
      vecs.push_back(ld("fill t6 evicts t3", DATA_ADDR_MODE_W, 32'h6008, 32'hA6000006, 1, 0, 32'hA6000006));
      vecs.push_back(ld("t4 still cached", DATA_ADDR_MODE_W, 32'h4008, 32'h0, 1, 1, 32'hA4000004));
      vecs.push_back(ld("t3 was evicted", DATA_ADDR_MODE_W, 32'h3008, 32'hB3000003, 1, 0, 32'hB3000003));
      vecs.push_back(ld("t2 survives", DATA_ADDR_MODE_W, 32'h2008, 32'h0, 1, 1, 32'hA2000002));
      vecs.push_back(ld("flush idle then ld 100", DATA_ADDR_MODE_W, 32'h100, 32'h0F0F0F0F, 1, 0, 32'h0F0F0F0F, 1'b1));
      vecs.push_back(ld("ld 124 after flush", DATA_ADDR_MODE_W, 32'h124, 32'h77777777, 2, 0, 32'h77777777));
      vecs.push_back(ld("ld 200 flush in fill", DATA_ADDR_MODE_W, 32'h200, 32'h20202020, 3, 0, 32'h20202020, 1'b0, 1'b1));
      vecs.push_back(ld("ld 200 hit", DATA_ADDR_MODE_W, 32'h200, 32'h0, 1, 1, 32'h20202020));
      vecs.push_back(ld("ld 124 hit", DATA_ADDR_MODE_W, 32'h124, 32'h0, 1, 1, 32'h77777777));
      vecs.push_back(ld("ld 100 hit", DATA_ADDR_MODE_W, 32'h100, 32'h0, 1, 1, 32'h0F0F0F0F));
      post_vecs.push_back(ld("ld 300 after rst", DATA_ADDR_MODE_W, 32'h300, 32'h30303030, 2, 0, 32'h30303030));
      post_vecs.push_back(ld("ld 200 after rst", DATA_ADDR_MODE_W, 32'h200, 32'h21212121, 1, 0, 32'h21212121));

      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_mode = DATA_ADDR_MODE_W;
      cpu_addr = 32'h0; cpu_wd = 32'h0; flush = 1'b0; mem_ack = 1'b0; mem_rd = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset cpu_ready", {31'd0, cpu_ready}, 32'd0);
      checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("reset cpu_rd", cpu_rd, 32'd0);
      checkCounters("reset");
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      cpu_we = 1'b0; cpu_mode = DATA_ADDR_MODE_W; cpu_addr = 32'h300; cpu_req = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk); #1;
         if (mem_req) seen = 1;
      end
      checkOutput("rst mid-fill mem_req seen", {31'd0, seen}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      checkOutput("rst mid-fill mem_req", {31'd0, mem_req}, 32'd0);
      exp_acc = 0; exp_hits = 0; exp_misses = 0;
      checkCounters("rst mid-fill");
      @(posedge clk); #1;

      for (int i = 0; i < post_vecs.size(); i++) applyStimulus(post_vecs[i]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
